// File: rtl/awg_pkg.sv
// Shared constants and elaboration helpers for the AWG timebase and its
// sample-pacing NCO.
package awg_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int ACC_W_DEFAULT  = 32;

  // Tick divider ratio; callers must pick rates that divide evenly.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width of the tick counter type for a given divider ratio.
  function automatic int tick_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/awg_timebase_if.sv
// Control/strobe bundle between the waveform datapath (master) and the
// timebase (slave).
interface awg_timebase_if
  import awg_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
);

  logic             en;
  logic [ACC_W-1:0] ftw;
  logic             tick_1s;
  logic             sample_ce;

  modport master (
    output en,
    output ftw,
    input  tick_1s,
    input  sample_ce
  );

  modport slave (
    input  en,
    input  ftw,
    output tick_1s,
    output sample_ce
  );

endinterface

// File: rtl/awg_timebase_ce_nco.sv
// Phase-accumulator NCO: emits a one-cycle clock enable on every carry out of
// the accumulator, so the average strobe rate is clk * ftw / 2^ACC_W.
module ce_nco
  import awg_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] ftw,
  output logic             ce
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, ftw};
    acc_d = acc_q;
    ce_d  = 1'b0;
    // Disabled cycles freeze the phase so pacing resumes without a restart.
    if (en) begin
      acc_d = sum[ACC_W-1:0];
      ce_d  = sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/awg_timebase.sv
// AWG timebase: registered 1 Hz-class tick divider plus an NCO-driven sample
// clock enable, both gated by a common enable.
module awg_timebase
  import awg_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int TICK_HZ = 1,
  parameter int ACC_W   = ACC_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  awg_timebase_if.slave bus
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int CNT_W = tick_cnt_w(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sample_ce;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (bus.en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  ce_nco #(
    .ACC_W (ACC_W)
  ) u_ce_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .ftw   (bus.ftw),
    .ce    (sample_ce)
  );

  assign bus.tick_1s   = tick_q;
  assign bus.sample_ce = sample_ce;

endmodule

// File: tb/tb_awg_timebase.sv
// Directed bench for awg_timebase: one DUT with DIV=10 for tick/NCO tests and
// one with DIV=4 for tick/strobe coincidence, both with an 8-bit accumulator.
module tb_awg_timebase;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   ce_cnt;

  awg_timebase_if #(.ACC_W(8)) bus_a ();
  awg_timebase_if #(.ACC_W(8)) bus_b ();

  awg_timebase #(
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .ACC_W   (8)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  awg_timebase #(
    .CLK_HZ  (4),
    .TICK_HZ (1),
    .ACC_W   (8)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    bus_a.en  = 1'b1;
    bus_a.ftw = 8'd0;
    bus_b.en  = 1'b0;
    bus_b.ftw = 8'd0;

    // Reset values
    #12;
    check("rst_tick_a", 32'(bus_a.tick_1s), 32'd0);
    check("rst_ce_a",   32'(bus_a.sample_ce), 32'd0);
    check("rst_tick_b", 32'(bus_b.tick_1s), 32'd0);
    check("rst_ce_b",   32'(bus_b.sample_ce), 32'd0);
    $display("step: reset values checked");

    // First tick after the 10th edge, then five more periods
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      check($sformatf("first_tick_e%0d", k), 32'(bus_a.tick_1s), 32'((k % 10) == 0));
      check($sformatf("ftw0_ce_e%0d", k), 32'(bus_a.sample_ce), 32'd0);
    end
    $display("step: first tick and 5 periods checked");

    // Enable gating at count 4 for 7 cycles
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("pre_gate_e%0d", k), 32'(bus_a.tick_1s), 32'd0);
    end
    bus_a.en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("gated_tick_e%0d", k), 32'(bus_a.tick_1s), 32'd0);
    end
    bus_a.en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("resume_tick_e%0d", k), 32'(bus_a.tick_1s), 32'(k == 6));
    end
    $display("step: enable gating checked");

    // ftw = 0: no strobes in 512 cycles
    ce_cnt = 0;
    for (int k = 0; k < 512; k++) begin
      step();
      if (bus_a.sample_ce) ce_cnt++;
    end
    check("ftw0_512", 32'(ce_cnt), 32'd0);

    // ftw = 128: every 2nd cycle
    bus_a.ftw = 8'd128;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("ftw128_e%0d", k), 32'(bus_a.sample_ce), 32'((k % 2) == 0));
    end

    // ftw = 64: every 4th cycle
    bus_a.ftw = 8'd64;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("ftw64_e%0d", k), 32'(bus_a.sample_ce), 32'((k % 4) == 0));
    end

    // ftw = 3: three strobes per 256 cycles
    bus_a.ftw = 8'd3;
    ce_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (bus_a.sample_ce) ce_cnt++;
    end
    check("ftw3_256", 32'(ce_cnt), 32'd3);
    $display("step: NCO rates checked");

    // Asynchronous reset while sample_ce is high
    bus_a.ftw = 8'd128;
    step();
    check("pre_rst_ce_lo", 32'(bus_a.sample_ce), 32'd0);
    step();
    check("pre_rst_ce_hi", 32'(bus_a.sample_ce), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_ce",   32'(bus_a.sample_ce), 32'd0);
    check("async_rst_tick", 32'(bus_a.tick_1s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("post_rst_ce_e%0d", k),   32'(bus_a.sample_ce), 32'((k % 2) == 0));
      check($sformatf("post_rst_tick_e%0d", k), 32'(bus_a.tick_1s), 32'(k == 10));
    end
    $display("step: asynchronous reset checked");

    // ftw change 64 -> 128 at acc = 192: phase carries over
    bus_a.ftw = 8'd64;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("chg64_e%0d", k), 32'(bus_a.sample_ce), 32'd0);
    end
    bus_a.ftw = 8'd128;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("chg128_e%0d", k), 32'(bus_a.sample_ce), 32'((k % 2) == 1));
    end
    $display("step: ftw change checked");

    // Coincidence on DIV=4, ftw=64
    bus_b.ftw = 8'd64;
    bus_b.en  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("coin_tick_e%0d", k), 32'(bus_b.tick_1s),   32'((k % 4) == 0));
      check($sformatf("coin_ce_e%0d", k),   32'(bus_b.sample_ce), 32'((k % 4) == 0));
    end
    $display("step: tick/strobe coincidence checked");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
